// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the FIFO write-port arbiter.
// Holds the FSM encoding, a clog2 helper and the reset value of the round-robin pointer.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

    // Pointer starts on the highest index so requester 0 wins the first scan.
    function automatic int last_owner_rst(input int num_req);
        return num_req - 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-side handshake plus FIFO write-port bundle shared by the arbiter and its users.
// master = requesters/FIFO model, slave = arbiter.
interface fifo_wr_arbiter_if #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8
);
    import fifo_arb_pkg::*;

    localparam int GID_W = clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_last;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_wr_full;
    logic                          fifo_wr_inc;
    logic [DATA_WIDTH-1:0]         fifo_wr_data;
    logic [GID_W-1:0]              grant_id;
    logic                          arb_busy;

    modport master (
        output req_valid, req_data, req_last, fifo_wr_full,
        input  req_ready, fifo_wr_inc, fifo_wr_data, grant_id, arb_busy
    );

    modport slave (
        input  req_valid, req_data, req_last, fifo_wr_full,
        output req_ready, fifo_wr_inc, fifo_wr_data, grant_id, arb_busy
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin pick: first valid requester after last_owner, wrapping modulo NUM_REQ.
// Zero latency; no handshake of its own.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int GID_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [GID_W-1:0]   last_owner,
    output logic               found,
    output logic [GID_W-1:0]   pick_id
);

    logic [GID_W:0]     start;
    logic [GID_W:0]     idx;
    logic [GID_W:0]     sum;
    logic [NUM_REQ-1:0] rot;

    always_comb begin
        start = {1'b0, last_owner} + 1'b1;
        // Doubled vector lets a plain shift act as a rotate starting at last_owner+1.
        rot   = NUM_REQ'({req_valid, req_valid} >> start);
        found = 1'b0;
        idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                found = 1'b1;
                idx   = (GID_W+1)'(i);
            end
        end
        sum = start + idx;
        if (sum >= (GID_W+1)'(NUM_REQ)) begin
            sum = sum - (GID_W+1)'(NUM_REQ);
        end
        pick_id = sum[GID_W-1:0];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin packet-locking arbiter feeding an async FIFO write port through a one-deep output stage.
// One IDLE cycle per grant, accept-to-write one cycle; fifo_wr_full stalls the stage and drops req_ready.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int MAX_BURST  = 4
) (
    input  logic             wr_clk,
    input  logic             wr_rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int GID_W = clog2(NUM_REQ);
    localparam int CNT_W = clog2(MAX_BURST + 1);
    localparam logic [GID_W-1:0] LAST_RST = GID_W'(last_owner_rst(NUM_REQ));
    localparam logic [CNT_W-1:0] CAP_CNT  = CNT_W'(MAX_BURST - 1);

    arb_state_t            state;
    logic [GID_W-1:0]      owner;
    logic [GID_W-1:0]      last_owner;
    logic [CNT_W-1:0]      beat_cnt;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_data;

    logic                  found;
    logic [GID_W-1:0]      pick_id;
    logic                  wr_inc;
    logic                  load_en;
    logic                  beat_acc;
    logic                  owner_vld;
    logic                  owner_last;
    logic [DATA_WIDTH-1:0] owner_dat;
    logic [NUM_REQ-1:0]    req_ready;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .GID_W   (GID_W)
    ) u_picker (
        .req_valid  (bus.req_valid),
        .last_owner (last_owner),
        .found      (found),
        .pick_id    (pick_id)
    );

    assign wr_inc     = out_valid & ~bus.fifo_wr_full;
    // Stage can take a new word when empty or when its current word leaves this cycle.
    assign load_en    = ~out_valid | wr_inc;
    assign owner_vld  = bus.req_valid[owner];
    assign owner_last = bus.req_last[owner];
    assign owner_dat  = bus.req_data[int'(owner)*DATA_WIDTH +: DATA_WIDTH];
    assign beat_acc   = (state == BUSY) & owner_vld & load_en;

    always_comb begin
        req_ready = '0;
        if (state == BUSY) begin
            req_ready[owner] = load_en;
        end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
        if (wr_rst) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= LAST_RST;
            beat_cnt   <= '0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            if (beat_acc) begin
                out_valid <= 1'b1;
                out_data  <= owner_dat;
            end else if (wr_inc) begin
                out_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (found) begin
                        owner    <= pick_id;
                        beat_cnt <= '0;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    // Grant stays locked if the owner stalls; only last or the burst cap frees it.
                    if (beat_acc) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (owner_last || beat_cnt == CAP_CNT) begin
                            last_owner <= owner;
                            state      <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.req_ready    = req_ready;
    assign bus.fifo_wr_inc  = wr_inc;
    assign bus.fifo_wr_data = out_data;
    assign bus.grant_id     = owner;
    assign bus.arb_busy     = (state == BUSY);

endmodule
